// File: rtl/pulse_seq_ctrl_if.sv
// pulse_seq_ctrl_if: control, configuration and status bundle for the pulse sequencer
interface pulse_seq_ctrl_if #(
  parameter int COUNT_BITS = 32,
  parameter int SHOT_BITS  = 16
);
  logic                  arm;
  logic                  abort;
  logic                  trig_in;
  logic [COUNT_BITS-1:0] cfg_period;
  logic [SHOT_BITS-1:0]  cfg_shots;
  logic                  cfg_retrig;
  logic                  logic_reset;
  logic                  out_en;
  logic                  armed;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic                  trig_miss;
  logic [SHOT_BITS-1:0]  shot_cnt;

  modport master (
    output arm, abort, trig_in, cfg_period, cfg_shots, cfg_retrig,
    input  logic_reset, out_en, armed, busy, done, cfg_err, trig_miss, shot_cnt
  );

  modport slave (
    input  arm, abort, trig_in, cfg_period, cfg_shots, cfg_retrig,
    output logic_reset, out_en, armed, busy, done, cfg_err, trig_miss, shot_cnt
  );
endinterface

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: arms on a strobe, waits for a synchronized trigger, then runs N fixed-length shots
module pulse_seq_ctrl #(
  parameter int COUNT_BITS  = 32,
  parameter int SHOT_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pulse_clk,
  input  logic              rst_n,
  pulse_seq_ctrl_if.slave   io
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_warm;
  logic                   r_trig_q;
  logic                   w_trig_pulse;

  logic [1:0]            r_state, w_state;
  logic [COUNT_BITS-1:0] r_cnt, w_cnt;
  logic [COUNT_BITS-1:0] r_period, w_period;
  logic [SHOT_BITS-1:0]  r_shots, w_shots;
  logic                  r_retrig, w_retrig;
  logic [SHOT_BITS-1:0]  r_shot_cnt, w_shot_cnt, w_shot_inc;
  logic                  r_trig_miss, w_trig_miss;
  logic                  r_logic_reset, w_logic_reset;
  logic                  r_cfg_err, w_cfg_err;
  logic                  r_out_en, r_armed, r_busy, r_done;
  logic                  w_last, w_reject;

  // r_warm masks edges until the synchronizer and edge flop hold real samples, so a trigger held through reset is not seen as a rising edge
  assign w_trig_pulse = r_sync[SYNC_STAGES-1] & ~r_trig_q & r_warm[SYNC_STAGES];
  assign w_shot_inc   = &r_shot_cnt ? r_shot_cnt : r_shot_cnt + SHOT_BITS'(1);
  assign w_last       = (SHOT_BITS+1)'(r_shot_cnt) + (SHOT_BITS+1)'(1) == (SHOT_BITS+1)'(r_shots);
  assign w_reject     = io.cfg_shots == '0 || io.cfg_period < COUNT_BITS'(2);

  // Trigger synchronizer, warm-up mask and previous-sample flop for edge detection
  always_ff @(posedge pulse_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_warm   <= '0;
      r_trig_q <= 1'b0;
    end else begin
      r_sync   <= (r_sync << 1) | SYNC_STAGES'(io.trig_in);
      r_warm   <= {r_warm[SYNC_STAGES-1:0], 1'b1};
      r_trig_q <= r_sync[SYNC_STAGES-1];
    end
  end

  // Next-state and datapath decisions; abort outranks trigger, trigger outranks arm
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_period      = r_period;
    w_shots       = r_shots;
    w_retrig      = r_retrig;
    w_shot_cnt    = r_shot_cnt;
    w_trig_miss   = r_trig_miss;
    w_logic_reset = 1'b0;
    w_cfg_err     = 1'b0;
    if (io.abort) begin
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_trig_pulse) begin
            w_state       = S_RUN;
            w_cnt         = r_period - COUNT_BITS'(1);
            w_logic_reset = 1'b1;
          end
        end
        S_RUN: begin
          if (w_trig_pulse) w_trig_miss = 1'b1;
          if (r_cnt == '0) begin
            w_shot_cnt = w_shot_inc;
            if (w_last) begin
              w_state = S_DONE;
            end else if (r_retrig) begin
              w_state = S_ARMED;
            end else begin
              w_cnt         = r_period - COUNT_BITS'(1);
              w_logic_reset = 1'b1;
            end
          end else begin
            w_cnt = r_cnt - COUNT_BITS'(1);
          end
        end
        default: begin
          if (io.arm) begin
            if (w_reject) begin
              w_state   = S_IDLE;
              w_cfg_err = 1'b1;
            end else begin
              w_state     = S_ARMED;
              w_period    = io.cfg_period;
              w_shots     = io.cfg_shots;
              w_retrig    = io.cfg_retrig;
              w_shot_cnt  = '0;
              w_trig_miss = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // State, shadow configuration and registered status outputs
  always_ff @(posedge pulse_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_period      <= '0;
      r_shots       <= '0;
      r_retrig      <= 1'b0;
      r_shot_cnt    <= '0;
      r_trig_miss   <= 1'b0;
      r_logic_reset <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_out_en      <= 1'b0;
      r_armed       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_period      <= w_period;
      r_shots       <= w_shots;
      r_retrig      <= w_retrig;
      r_shot_cnt    <= w_shot_cnt;
      r_trig_miss   <= w_trig_miss;
      r_logic_reset <= w_logic_reset;
      r_cfg_err     <= w_cfg_err;
      r_out_en      <= w_state == S_RUN;
      r_armed       <= w_state == S_ARMED;
      r_busy        <= w_state == S_ARMED || w_state == S_RUN;
      r_done        <= w_state == S_DONE;
    end
  end

  assign io.logic_reset = r_logic_reset;
  assign io.out_en      = r_out_en;
  assign io.armed       = r_armed;
  assign io.busy        = r_busy;
  assign io.done        = r_done;
  assign io.cfg_err     = r_cfg_err;
  assign io.trig_miss   = r_trig_miss;
  assign io.shot_cnt    = r_shot_cnt;
endmodule
